// File: rtl/wall_clock_ctrl.sv
// Wall clock timekeeping and set-time controller: BCD hh:mm:ss with carries, AM/PM and a mode/inc set FSM.
// Define CLOCK_24H_EN for a 24-hour build; the default build is 12-hour with AM/PM.
module wall_clock_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic [1:0] sel,
  output logic       setting,
  output logic       day_pulse
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_SET_HH = 2'd1,
    S_SET_MM = 2'd2,
    S_SET_SS = 2'd3
  } state_t;

  state_t     r_state, w_state_next;
  logic [7:0] r_hh, r_mm, r_ss;
  logic [7:0] w_hh_next, w_mm_next, w_ss_next;
  logic       r_pm, w_pm_next;
  logic       r_day, w_day_next;
  logic       r_setting;
  logic       w_hh_to_12;
  logic       w_midnight;

  function automatic logic [7:0] f_inc_59(input logic [7:0] v);
    if (v == 8'h59)           f_inc_59 = 8'h00;
    else if (v[3:0] == 4'h9)  f_inc_59 = {v[7:4] + 4'h1, 4'h0};
    else                      f_inc_59 = {v[7:4], v[3:0] + 4'h1};
  endfunction

`ifdef CLOCK_24H_EN
  localparam logic [7:0] HH_RESET = 8'h00;
  function automatic logic [7:0] f_inc_hh(input logic [7:0] v);
    if (v == 8'h23)           f_inc_hh = 8'h00;
    else if (v[3:0] == 4'h9)  f_inc_hh = {v[7:4] + 4'h1, 4'h0};
    else                      f_inc_hh = {v[7:4], v[3:0] + 4'h1};
  endfunction
  assign w_hh_to_12 = 1'b0;
  assign w_midnight = (r_hh == 8'h23);
`else
  localparam logic [7:0] HH_RESET = 8'h12;
  function automatic logic [7:0] f_inc_hh(input logic [7:0] v);
    if (v == 8'h12)           f_inc_hh = 8'h01;
    else if (v[3:0] == 4'h9)  f_inc_hh = {v[7:4] + 4'h1, 4'h0};
    else                      f_inc_hh = {v[7:4], v[3:0] + 4'h1};
  endfunction
  assign w_hh_to_12 = (r_hh == 8'h11);
  // Midnight is the 11 PM -> 12 AM step, i.e. the pm toggle from 1 to 0.
  assign w_midnight = (r_hh == 8'h11) && r_pm;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_RUN;
      r_hh      <= HH_RESET;
      r_mm      <= 8'h00;
      r_ss      <= 8'h00;
      r_pm      <= 1'b0;
      r_day     <= 1'b0;
      r_setting <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_hh      <= w_hh_next;
      r_mm      <= w_mm_next;
      r_ss      <= w_ss_next;
      r_pm      <= w_pm_next;
      r_day     <= w_day_next;
      r_setting <= (w_state_next != S_RUN);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hh_next    = r_hh;
    w_mm_next    = r_mm;
    w_ss_next    = r_ss;
    w_pm_next    = r_pm;
    w_day_next   = 1'b0;
    case (r_state)
      S_RUN: begin
        // The tick still lands when mode_btn leaves RUN on the same edge.
        if (tick) begin
          w_ss_next = f_inc_59(r_ss);
          if (r_ss == 8'h59) begin
            w_mm_next = f_inc_59(r_mm);
            if (r_mm == 8'h59) begin
              w_hh_next  = f_inc_hh(r_hh);
              w_pm_next  = r_pm ^ w_hh_to_12;
              w_day_next = w_midnight;
            end
          end
        end
        if (mode_btn) w_state_next = S_SET_HH;
      end
      S_SET_HH: begin
        if (mode_btn) begin
          w_state_next = S_SET_MM;
        end else if (inc_btn) begin
          w_hh_next = f_inc_hh(r_hh);
          w_pm_next = r_pm ^ w_hh_to_12;
        end
      end
      S_SET_MM: begin
        if (mode_btn)     w_state_next = S_SET_SS;
        else if (inc_btn) w_mm_next    = f_inc_59(r_mm);
      end
      S_SET_SS: begin
        if (mode_btn)     w_state_next = S_RUN;
        else if (inc_btn) w_ss_next    = f_inc_59(r_ss);
      end
      default: w_state_next = S_RUN;
    endcase
  end

  assign hh        = r_hh;
  assign mm        = r_mm;
  assign ss        = r_ss;
  assign pm        = r_pm;
  assign sel       = r_state;
  assign setting   = r_setting;
  assign day_pulse = r_day;

endmodule

// File: doc/wall_clock_ctrl.md
# wall_clock_ctrl

Time-keeping and time-set controller for the digital wall clock. Consumes the one-cycle-per-second enable from the 1 kHz divider and sequences three BCD field counters (hours, minutes, seconds), handling carries, 12/24-hour wrap and AM/PM. Also owns the user set-time state machine: a mode button walks through the fields, an increment button adjusts the selected field, and timekeeping pauses while setting.

## Interface
Parameters: none. Hour format is selected at compile time; see Configuration.

Ports:
- clk  in  1  system clock; same 1000 Hz clock as the divider.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-second enable; high for exactly one clk cycle per second.
- mode_btn  in  1  mode advance; each clk cycle high is one event (debounced and pulsed upstream).
- inc_btn  in  1  increment the selected field; each clk cycle high is one event.
- hh  out  8  hours, two BCD digits {tens, ones}.
- mm  out  8  minutes, BCD 00–59.
- ss  out  8  seconds, BCD 00–59.
- pm  out  1  PM flag; constant 0 in 24-hour build.
- sel  out  2  current state: 0=RUN, 1=SET_HH, 2=SET_MM, 3=SET_SS.
- setting  out  1  high when sel != 0.
- day_pulse  out  1  one-cycle pulse on midnight rollover in RUN.

## Operation
- All outputs are registered. On reset_n low, asynchronously: hh=8'h12 (12 h) or 8'h00 (24 h); mm=00; ss=00; pm=0; sel=RUN; day_pulse=0.
- FSM on mode_btn: RUN→SET_HH→SET_MM→SET_SS→RUN. No other transitions.
- RUN, tick=1:
  - ss += 1; at 59, ss wraps to 00 and carries to mm.
  - mm += 1 on carry; at 59, mm wraps to 00 and carries to hh.
  - 12 h hours: 12→01, 01→…→11, 11→12 toggles pm.
  - 24 h hours: 00→…→23, 23→00.
- RUN, day_pulse: high for one cycle when the hours wrap at midnight.
  - 24 h: 23:59:59 → 00:00:00.
  - 12 h: 11:59:59 with pm=1 → 12:00:00 with pm=0.
- RUN, inc_btn: ignored.
- SET_x states: tick is ignored and time is frozen. Seconds are not accumulated or caught up after exiting.
- SET_x, inc_btn=1: increment only the selected field, with no carry into other fields.
  - mm and ss wrap 59→00.
  - hh follows the same sequence as RUN, including the pm toggle on 11→12 in 12 h.
  - day_pulse is never asserted in SET states.
- Field arithmetic is per-digit BCD. The ones digit wraps 9→0 and increments tens. A field never holds a non-BCD or out-of-range value.
- Simultaneous events:
  - mode_btn with inc_btn: mode_btn wins; the inc is dropped.
  - RUN, tick with mode_btn: the tick is applied and sel becomes SET_HH on the same edge.
  - SET_SS, tick with mode_btn: sel becomes RUN and the tick is dropped.
- Reset mid-operation, including in any SET state, returns to the reset values above. There is no partial-state retention.

## Timing
- Latency is 1 cycle: the input event is sampled at edge N and outputs update after edge N; day_pulse is high for the cycle after edge N only.
- A full carry chain (ss, mm, hh, pm) resolves in one edge. There is no ripple across cycles.
- setting and sel change on the same edge.
- Back-to-back inc_btn cycles each increment once, so 60 consecutive cycles of inc_btn in SET_MM return mm to its start value.

## Configuration
- CLOCK_24H_EN defined: 24-hour format.
  - hh range 00–23; reset hh=00.
  - pm is tied 0.
- CLOCK_24H_EN undefined: 12-hour format.
  - hh range 01–12; reset hh=12.
  - pm is toggled on the 11→12 transition, in RUN and in SET_HH.

## Test plan
- Reset and run: release reset_n, apply 61 ticks → hh:mm:ss=12:01:01, pm=0, day_pulse never high (12 h build).
- Full carry: preset 11:59:59 pm=1 via SET states, return to RUN, apply one tick → next cycle 12:00:00, pm=0, day_pulse=1 for exactly one cycle. In the 24 h build, 23:59:59 → 00:00:00 with day_pulse=1.
- Set sequence: four mode_btn pulses → sel=1,2,3,0. In SET_MM, apply 3 inc_btn pulses plus continuous ticks → mm+3, ss unchanged, no carry into hh.
- Field wrap without carry: in SET_SS at ss=59, apply inc_btn → ss=00, mm unchanged. In SET_HH at hh=11 pm=0, apply inc_btn → hh=12, pm=1.
- Collisions: in RUN, tick and mode_btn in the same cycle → ss+1 and sel=1. In SET_SS, tick and mode_btn together → sel=0 and ss unchanged. In SET_HH, mode_btn and inc_btn together → sel=2 and hh unchanged.
- Async reset: assert reset_n low mid-cycle while in SET_MM at 07:42:10 → outputs are 12:00:00, sel=0, pm=0 before the next clk edge.
